// File: rtl/preamble_sync_ctrl_if.sv
// Detector-side bundle for preamble_sync_ctrl: sample-stream monitor
// plus peak strobe and magnitudes from preamble_detect.
interface preamble_sync_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_tvalid;
  logic                  in_tready;
  logic                  peak_stb;
  logic [DATA_WIDTH-1:0] pow_mag_tdata;
  logic [DATA_WIDTH-1:0] acorr_mag_tdata;

  modport master (
    output in_tvalid,
    output in_tready,
    output peak_stb,
    output pow_mag_tdata,
    output acorr_mag_tdata
  );

  modport slave (
    input in_tvalid,
    input in_tready,
    input peak_stb,
    input pow_mag_tdata,
    input acorr_mag_tdata
  );
endinterface

// File: rtl/preamble_sync_ctrl.sv
// Arm/clear/qualify/holdoff/capture sequencer for preamble_detect.
// Optional search timeout: define PREAMBLE_SYNC_TIMEOUT_EN.
module preamble_sync_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int CLR_CYCLES     = 4,
  parameter int THRESH_SHIFT_W = 4,
  parameter int TIMEOUT_CYCLES = 1048575
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      arm,
  input  logic                      auto_rearm,
  input  logic [CNT_WIDTH-1:0]      holdoff_len,
  input  logic [CNT_WIDTH-1:0]      capture_len,
  input  logic [THRESH_SHIFT_W-1:0] thresh_shift,
  input  logic [DATA_WIDTH-1:0]     pow_floor,
  preamble_sync_ctrl_if.slave       det,
  output logic                      det_clear,
  output logic                      gate,
  output logic                      sof,
  output logic                      eof,
  output logic                      busy,
  output logic                      abort,
  output logic                      timeout,
  output logic [2:0]                state,
  output logic [15:0]               det_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SEARCH  = 3'd2,
    S_HOLDOFF = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CLR_LAST = CNT_WIDTH'(CLR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]        hold_len_q, hold_len_d;
  logic [CNT_WIDTH-1:0]        cap_len_q, cap_len_d;
  logic [THRESH_SHIFT_W-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]       floor_q, floor_d;
  logic [15:0]                 det_count_q, det_count_d;
  logic                        abort_q, abort_d;
  logic                        beat, qual, in_cap, last_beat;

`ifdef PREAMBLE_SYNC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  assign beat      = det.in_tvalid & det.in_tready;
  assign qual      = det.peak_stb
                   & (det.pow_mag_tdata >= floor_q)
                   & (det.acorr_mag_tdata >= (det.pow_mag_tdata >> shift_q));
  assign in_cap    = (state_q == S_CAPTURE);
  assign last_beat = beat & (cnt_q == cap_len_q - ONE);

  // sof/eof are withheld on the abort cycle so a dropped window never ends cleanly
  assign gate      = in_cap;
  assign sof       = in_cap & enable & beat & (cnt_q == '0);
  assign eof       = in_cap & enable & last_beat;
  assign det_clear = (state_q == S_CLEAR);
  assign busy      = (state_q != S_IDLE);
  assign abort     = abort_q;
  assign state     = state_q;
  assign det_count = det_count_q;

`ifdef PREAMBLE_SYNC_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_len_d  = hold_len_q;
    cap_len_d   = cap_len_q;
    shift_d     = shift_q;
    floor_d     = floor_q;
    det_count_d = det_count_q;
    abort_d     = 1'b0;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    timeout_d   = 1'b0;
`endif
    if (state_q != S_IDLE && !enable) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm && enable) begin
            hold_len_d = holdoff_len;
            cap_len_d  = (capture_len == '0) ? ONE : capture_len;
            shift_d    = thresh_shift;
            floor_d    = pow_floor;
            state_d    = S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (cnt_q == CLR_LAST) state_d = S_SEARCH;
          else                   cnt_d   = cnt_q + ONE;
        end
        S_SEARCH: begin
          if (qual) begin
            if (det_count_q != 16'hFFFF)
              det_count_d = det_count_q + 16'd1;
            state_d = (hold_len_q == '0) ? S_CAPTURE : S_HOLDOFF;
          end
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_CLEAR;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
        S_HOLDOFF: begin
          if (beat) begin
            if (cnt_q == hold_len_q - ONE) state_d = S_CAPTURE;
            else                           cnt_d   = cnt_q + ONE;
          end
        end
        S_CAPTURE: begin
          if (beat) begin
            if (last_beat) state_d = S_DONE;
            else           cnt_d   = cnt_q + ONE;
          end
        end
        S_DONE:  state_d = auto_rearm ? S_CLEAR : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    // One shared counter, restarted on every state change
    if (state_d != state_q) begin
      cnt_d = '0;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
      to_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_len_q  <= '0;
      cap_len_q   <= '0;
      shift_q     <= '0;
      floor_q     <= '0;
      det_count_q <= '0;
      abort_q     <= 1'b0;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_len_q  <= hold_len_d;
      cap_len_q   <= cap_len_d;
      shift_q     <= shift_d;
      floor_q     <= floor_d;
      det_count_q <= det_count_d;
      abort_q     <= abort_d;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_preamble_sync_ctrl.sv
// Self-checking bench for preamble_sync_ctrl: vector table, directed
// corner sequences and random stimulus against a countdown reference model.
module tb_preamble_sync_ctrl;

  localparam int CLR = 4;
  localparam int TO  = 50;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, arm, auto_rearm;
  logic [15:0] holdoff_len, capture_len;
  logic [3:0]  thresh_shift;
  logic [15:0] pow_floor;
  logic        det_clear, gate, sof, eof, busy, abort, timeout;
  logic [2:0]  state;
  logic [15:0] det_count;

  preamble_sync_ctrl_if #(.DATA_WIDTH(16)) dif ();

  preamble_sync_ctrl #(
    .DATA_WIDTH(16), .CNT_WIDTH(16), .CLR_CYCLES(CLR),
    .THRESH_SHIFT_W(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .arm(arm),
    .auto_rearm(auto_rearm), .holdoff_len(holdoff_len),
    .capture_len(capture_len), .thresh_shift(thresh_shift),
    .pow_floor(pow_floor), .det(dif.slave),
    .det_clear(det_clear), .gate(gate), .sof(sof), .eof(eof),
    .busy(busy), .abort(abort), .timeout(timeout),
    .state(state), .det_count(det_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number plus remaining-work counters
  int          m_ph, m_clr_left, m_hold_left, m_cap_seen, m_srch;
  int          m_hold, m_cap, m_shift;
  int          m_floor, m_cnt;
  bit          m_abort, m_tout;

  logic        o_clr, o_gate, o_sof, o_eof, o_beat;

  task automatic m_reset();
    m_ph = 0; m_clr_left = 0; m_hold_left = 0; m_cap_seen = 0;
    m_srch = 0; m_hold = 0; m_cap = 0; m_shift = 0; m_floor = 0;
    m_cnt = 0; m_abort = 0; m_tout = 0;
  endtask

  function automatic bit m_beat();
    return dif.in_tvalid && dif.in_tready;
  endfunction

  function automatic bit m_qual();
    int p, a;
    p = int'(dif.pow_mag_tdata);
    a = int'(dif.acorr_mag_tdata);
    return dif.peak_stb && p >= m_floor && a >= (p >> m_shift);
  endfunction

  function automatic logic [25:0] m_expect();
    bit s, e;
    s = m_ph == 4 && m_beat() && enable && m_cap_seen == 0;
    e = m_ph == 4 && m_beat() && enable && m_cap_seen + 1 == m_cap;
    return {m_ph == 1, m_ph == 4, s, e, m_ph != 0, m_abort, m_tout,
            3'(m_ph), 16'(m_cnt)};
  endfunction

  task automatic m_update();
    bit b;
    b = m_beat();
    m_abort = 0;
    m_tout  = 0;
    if (m_ph != 0 && !enable) begin
      m_ph = 0;
      m_abort = 1;
    end else begin
      case (m_ph)
        0: if (arm && enable) begin
          m_hold  = int'(holdoff_len);
          m_cap   = capture_len == 0 ? 1 : int'(capture_len);
          m_shift = int'(thresh_shift);
          m_floor = int'(pow_floor);
          m_ph = 1; m_clr_left = CLR;
        end
        1: begin
          m_clr_left--;
          if (m_clr_left == 0) begin m_ph = 2; m_srch = 0; end
        end
        2: begin
          if (m_qual()) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_hold == 0) begin m_ph = 4; m_cap_seen = 0; end
            else begin m_ph = 3; m_hold_left = m_hold; end
          end else begin
            m_srch++;
`ifdef PREAMBLE_SYNC_TIMEOUT_EN
            if (m_srch == TO) begin
              m_tout = 1; m_ph = 1; m_clr_left = CLR;
            end
`endif
          end
        end
        3: if (b) begin
          m_hold_left--;
          if (m_hold_left == 0) begin m_ph = 4; m_cap_seen = 0; end
        end
        4: if (b) begin
          m_cap_seen++;
          if (m_cap_seen == m_cap) m_ph = 5;
        end
        5: if (auto_rearm) begin m_ph = 1; m_clr_left = CLR; end
           else m_ph = 0;
        default: m_ph = 0;
      endcase
    end
  endtask

  function automatic logic [25:0] dut_vec();
    return {det_clear, gate, sof, eof, busy, abort, timeout,
            state, det_count};
  endfunction

  task automatic drive(input logic a, input logic e, input logic v,
                       input logic r, input logic p,
                       input logic [15:0] pw, input logic [15:0] ac);
    arm = a; enable = e;
    dif.in_tvalid = v; dif.in_tready = r; dif.peak_stb = p;
    dif.pow_mag_tdata = pw; dif.acorr_mag_tdata = ac;
  endtask

  // Called #1 after inputs settle; compares, then advances one clock
  task automatic finish_cycle();
    logic [25:0] ex, ac;
    ex = m_expect();
    ac = dut_vec();
    o_clr = det_clear; o_gate = gate; o_sof = sof; o_eof = eof;
    o_beat = dif.in_tvalid & dif.in_tready;
    checks++;
    if (ac !== ex) begin
      errors++;
      $display("FAIL model t=%0t got=%h exp=%h", $time, ac, ex);
    end
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic step(input logic a, input logic e, input logic v,
                      input logic r, input logic p,
                      input logic [15:0] pw, input logic [15:0] ac);
    drive(a, e, v, r, p, pw, ac);
    #1;
    finish_cycle();
  endtask

  task automatic idle_step();
    step(0, 1, 1, 1, 0, 16'h0, 16'h0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        a, p;
    logic [15:0] pw, ac;
    logic [2:0]  st;
    logic        clr, g, s, e;
  } vec_t;

  vec_t tbl[23];

  int n_sof, n_eof, n_clr, beats_pre, prev_cnt;
  bit seen_gate;

  initial begin
    reset_n = 1'b0;
    auto_rearm = 0; holdoff_len = 0; capture_len = 3;
    thresh_shift = 2; pow_floor = 16'h0100;
    drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
    m_reset();
    #1;
    chk("reset_outputs", int'(dut_vec()), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic capture then qualification reject, hold=0 cap=3 shift=2 floor=0x100
    tbl[0]  = '{1, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 16'h1000, 16'h0800, 3'd2, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 16'h0000, 16'h0000, 3'd4, 0, 1, 1, 0};
    tbl[7]  = '{0, 0, 16'h0000, 16'h0000, 3'd4, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 16'h0000, 16'h0000, 3'd4, 0, 1, 0, 1};
    tbl[9]  = '{0, 0, 16'h0000, 16'h0000, 3'd5, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 0};
    tbl[13] = '{0, 0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 0};
    tbl[15] = '{0, 0, 16'h0000, 16'h0000, 3'd1, 1, 0, 0, 0};
    tbl[16] = '{0, 1, 16'h0080, 16'hFFFF, 3'd2, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 16'h1000, 16'h0100, 3'd2, 0, 0, 0, 0};
    tbl[18] = '{0, 1, 16'h1000, 16'h03FF, 3'd2, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 16'h0100, 16'h0040, 3'd2, 0, 0, 0, 0};
    tbl[20] = '{0, 0, 16'h0000, 16'h0000, 3'd4, 0, 1, 1, 0};
    tbl[21] = '{0, 0, 16'h0000, 16'h0000, 3'd4, 0, 1, 0, 0};
    tbl[22] = '{0, 0, 16'h0000, 16'h0000, 3'd4, 0, 1, 0, 1};

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].a, 1, 1, 1, tbl[i].p, tbl[i].pw, tbl[i].ac);
      #1;
      checks++;
      if ({state, det_clear, gate, sof, eof} !==
          {tbl[i].st, tbl[i].clr, tbl[i].g, tbl[i].s, tbl[i].e}) begin
        errors++;
        $display("FAIL vec%0d got=%h exp=%h", i,
                 {state, det_clear, gate, sof, eof},
                 {tbl[i].st, tbl[i].clr, tbl[i].g, tbl[i].s, tbl[i].e});
      end
      if (i == 18) chk("reject_count", int'(det_count), 1);
      finish_cycle();
    end
    idle_step();
    idle_step();
    chk("tbl_det_count", int'(det_count), 2);
    chk("tbl_back_idle", int'(state), 0);

    // Holdoff with bubbles: tvalid alternates, 5 beats skipped
    holdoff_len = 5; capture_len = 2;
    step(1, 1, 1, 1, 0, 16'h0, 16'h0);
    for (int i = 0; i < CLR; i++) idle_step();
    step(0, 1, 1, 1, 1, 16'h1000, 16'h0800);
    n_sof = 0; n_eof = 0; beats_pre = 0; seen_gate = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 1, logic'(i % 2 == 0), 1, 0, 16'h0, 16'h0);
      if (o_gate) seen_gate = 1;
      if (!seen_gate && o_beat) beats_pre++;
      if (o_sof) begin n_sof++; chk("sof_on_beat", int'(o_beat), 1); end
      if (o_eof) begin n_eof++; chk("eof_on_beat", int'(o_beat), 1); end
    end
    chk("holdoff_beats", beats_pre, 5);
    chk("holdoff_sof", n_sof, 1);
    chk("holdoff_eof", n_eof, 1);

    // Abort after beat 2 of 10, then a clean restart
    holdoff_len = 0; capture_len = 10;
    step(1, 1, 1, 1, 0, 16'h0, 16'h0);
    for (int i = 0; i < CLR; i++) idle_step();
    step(0, 1, 1, 1, 1, 16'h1000, 16'h0800);
    n_eof = 0;
    for (int i = 0; i < 2; i++) begin
      idle_step();
      if (o_eof) n_eof++;
    end
    step(0, 0, 1, 1, 0, 16'h0, 16'h0);
    if (o_eof) n_eof++;
    drive(0, 1, 1, 1, 0, 16'h0, 16'h0);
    #1;
    chk("abort_pulse", int'(abort), 1);
    chk("abort_gate", int'(gate), 0);
    chk("abort_state", int'(state), 0);
    finish_cycle();
    chk("abort_no_eof", n_eof, 0);
    chk("abort_one_cycle", int'(abort), 0);
    step(1, 1, 1, 1, 0, 16'h0, 16'h0);
    for (int i = 0; i < CLR; i++) idle_step();
    step(0, 1, 1, 1, 1, 16'h1000, 16'h0800);
    n_sof = 0; n_eof = 0;
    for (int i = 0; i < 14; i++) begin
      idle_step();
      if (o_sof) n_sof++;
      if (o_eof) n_eof++;
    end
    chk("restart_sof", n_sof, 1);
    chk("restart_eof", n_eof, 1);
    chk("restart_idle", int'(state), 0);

    // Arm with enable low stays idle, no abort
    step(1, 0, 1, 1, 0, 16'h0, 16'h0);
    #1;
    chk("arm_en_low_state", int'(state), 0);
    chk("arm_en_low_abort", int'(abort), 0);

    // Auto re-arm, capture=1, peaks 100 cycles apart
    auto_rearm = 1; capture_len = 1; holdoff_len = 0;
    prev_cnt = int'(det_count);
    n_sof = 0; n_eof = 0; n_clr = 0;
    for (int i = 0; i < 130; i++) begin
      logic pk, pc;
      pk = (i == 10 || i == 110);
      pc = o_clr;
      step(logic'(i == 0), 1, 1, 1, pk, 16'h1000, 16'h0800);
      if (o_sof) n_sof++;
      if (o_eof) n_eof++;
      if (o_clr && !pc) n_clr++;
    end
    chk("rearm_sof", n_sof, 2);
    chk("rearm_eof", n_eof, 2);
    chk("rearm_clr_bursts", n_clr, 3);
    chk("rearm_det_count", int'(det_count) - prev_cnt, 2);
    step(0, 0, 1, 1, 0, 16'h0, 16'h0);
    auto_rearm = 0;
    idle_step();

    // Random stimulus against the model
    for (int blk = 0; blk < 15; blk++) begin
      holdoff_len  = 16'($urandom_range(0, 6));
      capture_len  = 16'($urandom_range(0, 5));
      thresh_shift = 4'($urandom_range(0, 15));
      pow_floor    = 16'($urandom_range(0, 16'h0200));
      auto_rearm   = logic'($urandom_range(0, 1));
      for (int i = 0; i < 200; i++) begin
        step(logic'($urandom_range(0, 7) == 0),
             logic'($urandom_range(0, 63) != 0),
             logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 5) == 0),
             16'($urandom_range(0, 16'h1FFF)),
             16'($urandom_range(0, 16'h1FFF)));
      end
    end

    // Async reset between clock edges mid-capture
    auto_rearm = 0; holdoff_len = 0; capture_len = 10;
    step(0, 0, 1, 1, 0, 16'h0, 16'h0);
    step(1, 1, 1, 1, 0, 16'h0, 16'h0);
    for (int i = 0; i < CLR; i++) idle_step();
    step(0, 1, 1, 1, 1, 16'h1000, 16'h0800);
    idle_step();
    idle_step();
    chk("pre_reset_gate", int'(gate), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(dut_vec()), 0);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle_step();
    idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/preamble_sync_ctrl.md
Name: preamble_sync_ctrl

Overview:
- Sequencer for the preamble_detect datapath.
- Arms and clears the detector, then qualifies its peak strobe against a power-relative threshold.
- After a qualified peak, waits a programmable holdoff and opens a capture gate for a programmable number of input samples.
- Sits beside preamble_detect on the RX sample stream; drives its clear input and gates downstream frame capture.

Parameters:
- DATA_WIDTH, 16, width of pow/acorr magnitude inputs
- CNT_WIDTH, 16, width of holdoff/capture counters and config ports
- CLR_CYCLES, 4, cycles det_clear is held high on each (re)arm
- THRESH_SHIFT_W, 4, width of thresh_shift config port
- TIMEOUT_CYCLES, 1048575, search timeout in clk cycles (used only with optional feature)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  level; low aborts to IDLE
- arm  in  1  single-cycle start pulse
- auto_rearm  in  1  return to CLEAR instead of IDLE after DONE
- holdoff_len  in  CNT_WIDTH  samples to skip after peak
- capture_len  in  CNT_WIDTH  samples to gate
- thresh_shift  in  THRESH_SHIFT_W  qualification shift
- pow_floor  in  DATA_WIDTH  minimum pow_mag for qualification
- in_tvalid  in  1  sample stream valid (monitored)
- in_tready  in  1  sample stream ready (monitored)
- peak_stb  in  1  detector peak strobe
- pow_mag_tdata  in  DATA_WIDTH  detector power magnitude
- acorr_mag_tdata  in  DATA_WIDTH  detector autocorr magnitude
- det_clear  out  1  clear to preamble_detect
- gate  out  1  capture window active
- sof  out  1  pulse on first gated sample
- eof  out  1  pulse on last gated sample
- busy  out  1  state != IDLE
- abort  out  1  pulse on enable-drop abort
- timeout  out  1  pulse on search timeout (0 without optional feature)
- state  out  3  encoded state
- det_count  out  16  saturating count of qualified peaks

Behaviour:
- Reset (reset_n low, async): state=IDLE; all outputs 0; counters 0; latched config 0.
- Beat = in_tvalid & in_tready. Only beats advance holdoff/capture counters.
- State encoding: IDLE=0, CLEAR=1, SEARCH=2, HOLDOFF=3, CAPTURE=4, DONE=5.
- IDLE:
  - arm & enable -> CLEAR.
  - Latch holdoff_len, capture_len (0 latched as 1), thresh_shift, pow_floor on the arm cycle.
  - arm while not IDLE is ignored.
- CLEAR:
  - det_clear=1 for exactly CLR_CYCLES cycles, then -> SEARCH.
- SEARCH:
  - Qualified = peak_stb & (pow_mag >= pow_floor) & (acorr_mag >= (pow_mag >> thresh_shift)).
  - Comparison is unsigned, full DATA_WIDTH, combinational on the same cycle.
  - Qualified -> det_count += 1 (saturate at 0xFFFF); next state HOLDOFF, or CAPTURE if holdoff=0.
  - Unqualified peaks are ignored.
- HOLDOFF:
  - Count beats; after holdoff_len beats -> CAPTURE.
  - The beat that completes holdoff is not gated.
- CAPTURE:
  - gate=1 combinationally for the whole state.
  - First beat in state: sof=1. Beat number capture_len: eof=1, then -> DONE next cycle.
  - capture_len=1 asserts sof and eof on the same beat.
- DONE: one cycle, gate=0; -> CLEAR if auto_rearm else IDLE.
- Latency: qualified peak at cycle t -> gate high at t+1 when holdoff=0.
- Peaks in HOLDOFF/CAPTURE/DONE/CLEAR are ignored and not counted.
- enable low in any non-IDLE state:
  - -> IDLE next cycle; abort=1 for one cycle.
  - gate drops with no eof; det_clear deasserts.
- Counters never wrap; the compare is on equality with the latched length.
- arm and enable-low on the same cycle: stay IDLE, no abort.

Optional Feature:
- Macro: PREAMBLE_SYNC_TIMEOUT_EN.
- Defined:
  - SEARCH counts clk cycles; at TIMEOUT_CYCLES without a qualified peak, pulse timeout for one cycle and -> CLEAR.
  - The counter resets on entry to SEARCH.
- Undefined: no counter logic; timeout tied 0; SEARCH waits indefinitely.

Test Plan:
- Basic capture:
  - Stimulus: reset, arm, holdoff=0, capture=3, beats every cycle, pow=0x1000, acorr=0x0800, shift=2, floor=0x0100, peak at cycle 20.
  - Expected: det_clear high 4 cycles; gate high 3 beats; sof on 1st beat, eof on 3rd; det_count=1; state returns to 0.
- Qualification reject:
  - Stimulus: peaks with pow=0x0080 (< floor 0x0100), then acorr=0x0100 with pow=0x1000 and shift=2 (0x0100 < 0x0400).
  - Expected: both ignored, det_count=0, stays SEARCH.
- Holdoff with bubbles:
  - Stimulus: holdoff=5, capture=2, in_tvalid alternating 1/0.
  - Expected: gate rises only after the 5th beat; sof and eof each on a valid beat.
- Abort:
  - Stimulus: enable dropped mid-CAPTURE, after beat 2 of 10.
  - Expected: abort pulse; gate low next cycle; no eof; state=0; a new arm restarts cleanly.
- Auto re-arm:
  - Stimulus: auto_rearm=1, two qualified peaks separated by 100 cycles, capture=1.
  - Expected: two sof/eof pairs; det_clear burst after each DONE; det_count=2.
- Timeout (PREAMBLE_SYNC_TIMEOUT_EN, TIMEOUT_CYCLES=50):
  - Stimulus: no peaks.
  - Expected: timeout pulse 50 cycles after SEARCH entry, then CLEAR again.
- Async reset mid-CAPTURE (reset_n low between clock edges):
  - Expected: all outputs 0 immediately.
